// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling at
// OVERSAMPLE clocks per bit, and a small show-ahead receive FIFO.
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overflow
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync1_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_wrap;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          frame_err_q, frame_err_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          full, pop, do_push;

    assign cnt_wrap = (cnt_q == FULL_M1) ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                cnt_d = cnt_wrap;
                if (cnt_q == FULL_M1) begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_wrap;
                // Leaving mid-stop-bit lets an immediately following start edge be caught.
                if (cnt_q == FULL_M1) begin
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx_pin;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign full    = (count_q == DEPTH_C);
    assign pop     = rd_en && (count_q != '0);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !do_push) count_q <= count_q - 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = (count_q != '0);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: recovers bytes from one serial line by oversampling at OVERSAMPLE clocks per bit.
- Received bytes go into a small show-ahead FIFO read by downstream logic.
- Flags framing errors and FIFO overflow.
- Companion to the team's 8N1 transmitters; used for loopback and self-test. Its clock runs at OVERSAMPLE × the transmit bit rate.

Parameters:
- OVERSAMPLE, 8, clocks per bit period. Must be even and at least 4.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_pin  input  1  asynchronous serial input; idles high.
- rd_en  input  1  pop request; only acts when data_valid is 1.
- data_out  output  8  byte at the FIFO head; valid when data_valid is 1.
- data_valid  output  1  FIFO not empty.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overflow  output  1  sticky; set when a good byte arrives while the FIFO is full.

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - Synchronizer flops: 1.
  - State: IDLE.
  - Sample counter, bit counter, shift register: 0.
  - FIFO pointers and count: 0.
  - data_valid = 0, frame_err = 0, overflow = 0, data_out = 0x00.
- Reset mid-frame abandons the frame with no push and no flag.

Input synchronizer:
- rx_pin passes through a 2-flop synchronizer. Output is rx_s.
- All timing below is relative to T0, the first cycle IDLE sees rx_s = 0.

State machine:
- IDLE:
  - rx_s = 0 → START; clear the sample counter.
- START:
  - At T0 + OVERSAMPLE/2, sample rx_s.
  - Sample 1 → false start; go to IDLE with no flag.
  - Sample 0 → DATA; bit counter = 0.
- DATA:
  - Bit i (0..7) is sampled at T0 + OVERSAMPLE/2 + OVERSAMPLE*(i+1).
  - Shift LSB first: shreg <= {rx_s, shreg[7:1]}.
  - After bit 7 → STOP.
- STOP:
  - Sample at T0 + OVERSAMPLE/2 + 9*OVERSAMPLE.
  - Sample 1 → push shreg into the FIFO; go to IDLE.
  - Sample 0 → frame_err = 1 on the next cycle only; byte discarded; go to BREAK.
- BREAK:
  - Stay until rx_s = 1, then go to IDLE. A held-low line gives exactly one frame_err.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge immediately after the stop bit is caught. No extra idle bit is needed.

Counter and width rules:
- Sample counter is $clog2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE-1.
- Bit counter is 3 bits.

FIFO (show-ahead):
- Push latency: a byte pushed at stop-sample cycle S appears on data_out with data_valid = 1 at cycle S+1.
- Pop: rd_en && data_valid pops the head. The next entry, or data_valid = 0, shows from the next cycle.
- rd_en while empty is ignored.
- Push when full with no pop: byte dropped, FIFO contents unchanged, overflow set to 1. overflow is cleared only by reset.
- Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
- Push and pop in the same cycle when count = 1: new byte becomes the head next cycle; data_valid stays 1.
- data_out holds its last value when the FIFO is empty; it is don't-care for checking.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits.

Test Plan:
1. Single byte, OVERSAMPLE=8: line idle, then send 0x54 ('T') 8N1 at 8 clk/bit, rd_en = 0 → data_valid rises 1 cycle after the stop sample; data_out = 0x54; frame_err and overflow stay 0.
2. Back-to-back stream: send "Hi\r\n" (0x48 0x69 0x0D 0x0A) with no idle gap, then pop 4 times → bytes come out in order; data_valid = 0 after the 4th pop.
3. False start: rx_pin low for 2 clocks (less than OVERSAMPLE/2), then high → no push, no frame_err, state back to IDLE; a following 0xA5 is received correctly.
4. Framing error: send 0x3C with the stop bit forced low, then hold low for 40 clocks, then release → exactly one frame_err pulse; FIFO empty. Next frame 0x3C is received OK.
5. Overflow: send 5 bytes 0x01..0x05 without reads (FIFO_DEPTH=4) → overflow = 1 after byte 5; pops return 0x01..0x04. Then pop while receiving 0x06 at the full boundary (same-cycle push/pop) → no additional loss.
6. Reset mid-frame: assert reset during data bit 4 of 0xFF → all outputs at reset values the next cycle; a subsequent 0x81 is received correctly.
